// File: rtl/ps2_host_tx_if.sv
// CPU-side handshake bundle for the PS/2 host transmitter.
//   DAT_I  : byte to transmit, sampled when a strobe is accepted
//   STB_I  : transmit request, accepted only while BUSY_O is low
//   BUSY_O : transfer in progress
//   DONE_O : one-cycle pulse at the end of every transfer (success or failure)
//   ERR_O  : status of the last transfer (1 = no ack or timeout)
interface ps2_host_tx_if;
    logic [7:0] DAT_I;
    logic       STB_I;
    logic       BUSY_O;
    logic       DONE_O;
    logic       ERR_O;

    // CPU side drives the request, transmitter reports status.
    modport master (output DAT_I, output STB_I, input BUSY_O, input DONE_O, input ERR_O);
    modport slave  (input DAT_I, input STB_I, output BUSY_O, output DONE_O, output ERR_O);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the attached
// device through open-collector output enables on the clock/data pair.
//   CLK_I, RST_I       : system clock, synchronous active-high reset
//   bus (slave)        : CPU strobe/busy/done/err handshake with data byte
//   PS2C_I, PS2D_I     : raw PS/2 clock/data lines (asynchronous)
//   PS2C_OE_O          : 1 = pull the PS/2 clock line low
//   PS2D_OE_O          : 1 = pull the PS/2 data line low
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned RTS_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    ps2_host_tx_if.slave  bus,
    input  logic          PS2C_I,
    input  logic          PS2D_I,
    output logic          PS2C_OE_O,
    output logic          PS2D_OE_O
);

    localparam int unsigned DLY_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
    localparam int unsigned WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned SHIFT_W = 10;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INHIBIT  = 3'd1;
    localparam logic [2:0] S_RTS      = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_ACK      = 3'd4;
    localparam logic [2:0] S_WAITIDLE = 3'd5;

    // Line synchronizers and clock edge history.
    logic c_meta, c_sync, c_prev;
    logic d_meta, d_sync;
    logic fall_c;

    // Reset to the idle-bus level so no spurious edge appears after reset.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            c_meta <= 1'b1;
            c_sync <= 1'b1;
            c_prev <= 1'b1;
            d_meta <= 1'b1;
            d_sync <= 1'b1;
        end else begin
            c_meta <= PS2C_I;
            c_sync <= c_meta;
            c_prev <= c_sync;
            d_meta <= PS2D_I;
            d_sync <= d_meta;
        end
    end

    assign fall_c = c_prev & ~c_sync;

    logic [2:0]         state, state_n;
    logic [DLY_W-1:0]   dly, dly_n;
    logic [WD_W-1:0]    wd, wd_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [SHIFT_W-1:0] shift, shift_n;
    logic               ack_err, ack_err_n;
    logic               busy, busy_n;
    logic               done, done_n;
    logic               err, err_n;
    logic               c_oe, c_oe_n;
    logic               d_oe, d_oe_n;

    // State and datapath registers.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state   <= S_IDLE;
            dly     <= '0;
            wd      <= '0;
            idx     <= '0;
            shift   <= '0;
            ack_err <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            c_oe    <= 1'b0;
            d_oe    <= 1'b0;
        end else begin
            state   <= state_n;
            dly     <= dly_n;
            wd      <= wd_n;
            idx     <= idx_n;
            shift   <= shift_n;
            ack_err <= ack_err_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
            c_oe    <= c_oe_n;
            d_oe    <= d_oe_n;
        end
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_n   = state;
        dly_n     = dly;
        wd_n      = wd;
        idx_n     = idx;
        shift_n   = shift;
        ack_err_n = ack_err;
        busy_n    = busy;
        done_n    = 1'b0;
        err_n     = err;
        c_oe_n    = c_oe;
        d_oe_n    = d_oe;

        case (state)
            S_IDLE: begin
                c_oe_n = 1'b0;
                d_oe_n = 1'b0;
                if (bus.STB_I) begin
                    // Frame LSB first: data, odd parity, stop; start bit comes from RTS.
                    shift_n = {1'b1, ~^bus.DAT_I, bus.DAT_I};
                    err_n   = 1'b0;
                    busy_n  = 1'b1;
                    c_oe_n  = 1'b1;
                    dly_n   = DLY_W'(INHIBIT_CYCLES - 1);
                    state_n = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (dly == '0) begin
                    d_oe_n  = 1'b1;
                    dly_n   = DLY_W'(RTS_CYCLES - 1);
                    state_n = S_RTS;
                end else begin
                    dly_n = dly - DLY_W'(1);
                end
            end

            S_RTS: begin
                if (dly == '0) begin
                    c_oe_n  = 1'b0;
                    idx_n   = '0;
                    wd_n    = WD_W'(TIMEOUT_CYCLES);
                    state_n = S_SEND;
                end else begin
                    dly_n = dly - DLY_W'(1);
                end
            end

            S_SEND: begin
                if (fall_c) begin
                    d_oe_n  = ~shift[0];
                    shift_n = {1'b0, shift[SHIFT_W-1:1]};
                    idx_n   = idx + IDX_W'(1);
                    // Tenth edge puts out the stop bit.
                    if (idx == IDX_W'(9)) begin
                        state_n = S_ACK;
                    end
                end
            end

            S_ACK: begin
                if (fall_c) begin
                    ack_err_n = d_sync;
                    state_n   = S_WAITIDLE;
                end
            end

            S_WAITIDLE: begin
                if (c_sync && d_sync) begin
                    done_n  = 1'b1;
                    err_n   = ack_err;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end

            default: begin
                c_oe_n  = 1'b0;
                d_oe_n  = 1'b0;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase

        // Watchdog while the device owns the clock; a silent device aborts the transfer.
        if ((state == S_SEND) || (state == S_ACK) || (state == S_WAITIDLE)) begin
            if (fall_c) begin
                wd_n = WD_W'(TIMEOUT_CYCLES);
            end else if (wd == '0) begin
                c_oe_n  = 1'b0;
                d_oe_n  = 1'b0;
                err_n   = 1'b1;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end else begin
                wd_n = wd - WD_W'(1);
            end
        end
    end

    assign bus.BUSY_O = busy;
    assign bus.DONE_O = done;
    assign bus.ERR_O  = err;
    assign PS2C_OE_O  = c_oe;
    assign PS2D_OE_O  = d_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on open-collector lines,
// expected transfers queued at strobe time and checked at each DONE_O pulse.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 20;
    localparam int unsigned RTSC = 8;
    localparam int unsigned TO   = 400;
    localparam int unsigned HALF = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    logic c_oe, d_oe;
    logic dev_c = 1'b0;
    logic dev_d = 1'b0;
    wire  ps2c = ~(c_oe | dev_c);
    wire  ps2d = ~(d_oe | dev_d);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTSC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK_I     (clk),
        .RST_I     (rst),
        .bus       (bus.slave),
        .PS2C_I    (ps2c),
        .PS2D_I    (ps2d),
        .PS2C_OE_O (c_oe),
        .PS2D_OE_O (d_oe)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       err;
        bit         chk_frame;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Device model: answers a request-to-send with 11 clocks, samples on rising edges.
    int         stop_after = 11;
    bit         no_ack     = 1'b0;
    logic [10:0] rx;
    int         dev_k      = 0;
    bit         dev_busy   = 1'b0;
    int         edge5_cyc  = 0;
    logic       prev_c_oe  = 1'b0;
    bit         req;

    initial begin
        forever begin
            @(negedge clk);
            req = (prev_c_oe === 1'b1) && (c_oe === 1'b0) && (d_oe === 1'b1);
            prev_c_oe = c_oe;
            if (req) begin
                dev_busy = 1'b1;
                dev_k    = 0;
                rx       = '1;
                rx[0]    = ps2d;
                repeat (10) @(negedge clk);
                for (int k = 1; k <= 11; k++) begin
                    if (k > stop_after) break;
                    dev_c = 1'b1;
                    dev_k = k;
                    if (k == 5) edge5_cyc = cyc;
                    if (k == 11 && !no_ack) dev_d = 1'b1;
                    repeat (HALF) @(negedge clk);
                    dev_c = 1'b0;
                    if (k <= 10) rx[k] = ps2d;
                    repeat (HALF) @(negedge clk);
                    dev_d = 1'b0;
                end
                dev_busy  = 1'b0;
                prev_c_oe = c_oe;
            end
        end
    end

    // Scoreboard monitor: every DONE_O pulse retires one queued transfer.
    int   done_cnt  = 0;
    int   done_cyc  = 0;
    logic done_prev = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (bus.DONE_O === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_width", 32'(done_prev), 32'd0);
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("err_at_done", 32'(bus.ERR_O), 32'(mon_e.err));
                if (mon_e.chk_frame)
                    check("frame", 32'(rx), 32'({1'b1, ~^mon_e.data, mon_e.data, 1'b0}));
            end
            check("busy_at_done", 32'(bus.BUSY_O), 32'd0);
            check("oe_at_done", 32'({c_oe, d_oe}), 32'd0);
        end
        done_prev = bus.DONE_O;
    end

    task automatic strobe(input logic [7:0] b, input bit push, input bit exp_err, input bit chk);
        exp_t e;
        @(negedge clk);
        bus.DAT_I = b;
        bus.STB_I = 1'b1;
        if (push) begin
            e.data = b; e.err = exp_err; e.chk_frame = chk;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.STB_I = 1'b0;
        check("busy_on_accept", 32'(bus.BUSY_O), 32'd1);
        check("err_cleared", 32'(bus.ERR_O), 32'd0);
        check("clk_inhibit_on", 32'(c_oe), 32'd1);
    endtask

    task automatic measure_hold();
        int hold = 0;
        int d_at = -1;
        while (c_oe === 1'b1 && hold < 200) begin
            if (d_oe === 1'b1 && d_at < 0) d_at = hold;
            hold++;
            @(negedge clk);
        end
        check("clk_hold_len", 32'(hold), 32'(INH + RTSC));
        check("inhibit_len", 32'(d_at), 32'(INH));
    endtask

    task automatic wait_done(input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done_cnt != start), 32'd1);
    endtask

    task automatic wait_dev_idle();
        int n = 0;
        while (dev_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("dev_idle", 32'(dev_busy), 32'd0);
    endtask

    initial begin
        int seen;
        int base;
        int n;
        int lat;

        // Reset with a strobe pending: nothing may start.
        rst       = 1'b1;
        bus.STB_I = 1'b1;
        bus.DAT_I = 8'hED;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_outs", 32'({bus.BUSY_O, bus.DONE_O, bus.ERR_O, c_oe, d_oe}), 32'd0);
        end
        rst       = 1'b0;
        bus.STB_I = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_reset", 32'({bus.BUSY_O, c_oe, d_oe}), 32'd0);

        // Normal transfers with ack.
        strobe(8'hED, 1'b1, 1'b0, 1'b1); measure_hold(); wait_done(2000); wait_dev_idle();
        strobe(8'hF4, 1'b1, 1'b0, 1'b1); measure_hold(); wait_done(2000); wait_dev_idle();
        strobe(8'h00, 1'b1, 1'b0, 1'b1); measure_hold(); wait_done(2000); wait_dev_idle();

        // Device withholds the ack.
        no_ack = 1'b1;
        strobe(8'hEE, 1'b1, 1'b1, 1'b1); wait_done(2000); wait_dev_idle();
        repeat (10) @(negedge clk);
        check("err_held", 32'(bus.ERR_O), 32'd1);
        no_ack = 1'b0;

        // Device goes silent after the fifth clock: watchdog abort.
        stop_after = 5;
        strobe(8'h12, 1'b1, 1'b1, 1'b0); wait_done(2000);
        lat = done_cyc - edge5_cyc;
        check("timeout_latency_ok", 32'(lat >= int'(TO) - 2 && lat <= int'(TO) + 12), 32'd1);
        wait_dev_idle();
        stop_after = 11;
        strobe(8'hFF, 1'b1, 1'b0, 1'b1); measure_hold(); wait_done(2000); wait_dev_idle();

        // Strobe while busy is dropped, not queued.
        strobe(8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        bus.DAT_I = 8'h55;
        bus.STB_I = 1'b1;
        @(negedge clk);
        bus.STB_I = 1'b0;
        wait_done(2000);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.BUSY_O !== 1'b0) seen++;
        end
        check("no_queued_strobe", 32'(seen), 32'd0);
        wait_dev_idle();

        // Reset in the middle of SEND.
        strobe(8'h3C, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (dev_k < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reached_send", 32'(dev_k >= 3), 32'd1);
        base = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_release", 32'({c_oe, d_oe, bus.BUSY_O}), 32'd0);
        wait_dev_idle();
        repeat (50) @(negedge clk);
        check("no_done_on_rst", 32'(done_cnt), 32'(base));

        strobe(8'hED, 1'b1, 1'b0, 1'b1); measure_hold(); wait_done(2000); wait_dev_idle();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
